// File: rtl/hazard_detect_unit_if.sv
// rtl/hazard_detect_unit_if.sv - hazard unit pipeline-side signal bundle
interface hazard_detect_unit_if;
    logic [4:0] ID_Rs;
    logic [4:0] ID_Rt;
    logic       ID_UseRt;
    logic       ID_Jump;
    logic       ID_Branch;
    logic [4:0] EX_Rw;
    logic       EX_MemRead;
    logic       PCWrite;
    logic       IFWrite;
    logic       Bubble;

    // Pipeline side: supplies ID/EX decode info, consumes the stall/flush controls
    modport master (
        output ID_Rs, ID_Rt, ID_UseRt, ID_Jump, ID_Branch, EX_Rw, EX_MemRead,
        input  PCWrite, IFWrite, Bubble
    );

    // Hazard unit side
    modport slave (
        input  ID_Rs, ID_Rt, ID_UseRt, ID_Jump, ID_Branch, EX_Rw, EX_MemRead,
        output PCWrite, IFWrite, Bubble
    );
endinterface

// File: rtl/hazard_detect_unit.sv
// rtl/hazard_detect_unit.sv - load-use/jump/branch stall and flush controller (optional HAZARD_STALL_CNT_EN)
module hazard_detect_unit (
    input  logic                 CLK,
    input  logic                 Reset_L,
    hazard_detect_unit_if.slave  hz
`ifdef HAZARD_STALL_CNT_EN
    ,
    output logic [15:0]          StallCount
`endif
);

    typedef enum logic [2:0] {
        NO_HAZ   = 3'd0,
        JUMP     = 3'd1,
        BR_EX    = 3'd2,
        BR_FETCH = 3'd3
    } state_t;

    state_t state;
    state_t nextState;
    logic   loadUse;
    logic   pcWrite;
    logic   ifWrite;
    logic   bubble;

    // A load in EX whose destination feeds the ID instruction; $zero never creates a hazard
    assign loadUse = hz.EX_MemRead && (hz.EX_Rw != 5'd0) &&
                     ((hz.EX_Rw == hz.ID_Rs) || (hz.ID_UseRt && (hz.EX_Rw == hz.ID_Rt)));

    // Mealy outputs and next state; unused encodings fall to the safe stall defaults
    always_comb begin
        pcWrite   = 1'b0;
        ifWrite   = 1'b0;
        bubble    = 1'b1;
        nextState = NO_HAZ;
        case (state)
            NO_HAZ: begin
                if (loadUse) begin
                    pcWrite   = 1'b0;
                    ifWrite   = 1'b0;
                    bubble    = 1'b1;
                    nextState = NO_HAZ;
                end else if (hz.ID_Jump) begin
                    pcWrite   = 1'b1;
                    ifWrite   = 1'b1;
                    bubble    = 1'b0;
                    nextState = JUMP;
                end else if (hz.ID_Branch) begin
                    pcWrite   = 1'b0;
                    ifWrite   = 1'b1;
                    bubble    = 1'b0;
                    nextState = BR_EX;
                end else begin
                    pcWrite   = 1'b1;
                    ifWrite   = 1'b1;
                    bubble    = 1'b0;
                    nextState = NO_HAZ;
                end
            end
            JUMP: begin
                pcWrite   = 1'b1;
                ifWrite   = 1'b1;
                bubble    = 1'b1;
                nextState = NO_HAZ;
            end
            BR_EX: begin
                pcWrite   = 1'b1;
                ifWrite   = 1'b0;
                bubble    = 1'b1;
                nextState = BR_FETCH;
            end
            BR_FETCH: begin
                pcWrite   = 1'b1;
                ifWrite   = 1'b1;
                bubble    = 1'b1;
                nextState = NO_HAZ;
            end
            default: begin
                pcWrite   = 1'b0;
                ifWrite   = 1'b0;
                bubble    = 1'b1;
                nextState = NO_HAZ;
            end
        endcase
        // Reset holds the pipeline frozen with a bubble regardless of state
        if (!Reset_L) begin
            pcWrite = 1'b0;
            ifWrite = 1'b0;
            bubble  = 1'b1;
        end
    end

    assign hz.PCWrite = pcWrite;
    assign hz.IFWrite = ifWrite;
    assign hz.Bubble  = bubble;

    // State register; reset abandons any jump/branch sequence in flight
    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            state <= NO_HAZ;
        end else begin
            state <= nextState;
        end
    end

`ifdef HAZARD_STALL_CNT_EN
    logic [15:0] stallCnt;

    // Count every lost cycle (PC held or bubble injected), saturating at all-ones
    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            stallCnt <= 16'd0;
        end else if ((!pcWrite || bubble) && (stallCnt != 16'hFFFF)) begin
            stallCnt <= stallCnt + 16'd1;
        end
    end

    assign StallCount = stallCnt;
`endif

endmodule
